// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch front end feeding the IF/ID register. Owns the PC and
//   keeps at most one word read outstanding to instruction memory. It holds
//   a returned instruction while downstream stalls, and discards an
//   in-flight fetch when a branch/jump redirect arrives.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   o_imem_req/addr       read request and word address (always the PC)
//   i_imem_ready          memory accepts the request this cycle
//   i_imem_rvalid/rdata   read response
//   i_redirect/_pc        taken branch/jump and its target (bits [1:0] ignored)
//   i_stall               downstream cannot take the instruction this cycle
//   o_pc, o_instruction,
//   o_pc_plus_4, o_valid  bundle presented to the IF/ID register
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | requesting a fetch at pc
// WAIT  | request accepted, awaiting read data (bypassed to the output)
// HOLD  | data buffered because downstream stalled
// DROP  | redirected while waiting; the stale response will be discarded
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_4,
  output logic        o_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buffer, buffer_nxt;
  logic [31:0] redirect_pc_al;
  logic [31:0] pc_inc;
  logic        present;

  assign redirect_pc_al = {i_redirect_pc[31:2], 2'b00};
  assign pc_inc         = pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_REQ;
      pc     <= RESET_ADDR;
      buffer <= NOP;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      buffer <= buffer_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    buffer_nxt = buffer;
    case (state)
      S_REQ: begin
        if (i_redirect)        pc_nxt    = redirect_pc_al;
        else if (i_imem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (i_redirect) begin
            pc_nxt    = redirect_pc_al;
            state_nxt = S_REQ;
          end else if (!i_stall) begin
            pc_nxt    = pc_inc;
            state_nxt = S_REQ;
          end else begin
            buffer_nxt = i_imem_rdata;
            state_nxt  = S_HOLD;
          end
        end else if (i_redirect) begin
          // The response is still coming; it must be swallowed before the
          // next request so responses cannot be mismatched to addresses.
          pc_nxt    = redirect_pc_al;
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          pc_nxt    = redirect_pc_al;
          state_nxt = S_REQ;
        end else if (!i_stall) begin
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (i_redirect)    pc_nxt    = redirect_pc_al;
        if (i_imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Gating with i_rst keeps the bundle invalid during the reset cycle itself,
  // whatever state the FSM was in.
  assign present       = (state == S_WAIT && i_imem_rvalid) || (state == S_HOLD);
  assign o_valid       = present && !i_redirect && !i_rst;
  assign o_instruction = !o_valid           ? NOP :
                         (state == S_HOLD)  ? buffer : i_imem_rdata;
  assign o_imem_req    = (state == S_REQ) && !i_redirect && !i_rst;
  assign o_imem_addr   = pc;
  assign o_pc          = pc;
  assign o_pc_plus_4   = pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit against a small single-outstanding memory model with
//   configurable response latency. Each accepted request pushes its expected
//   {pc, instruction} to a scoreboard queue; presented instructions are
//   compared against the queue head and popped when consumed. Redirects and
//   resets flush the queue. Request, PC and valid timing are checked every
//   cycle from a protocol-level expectation.
module tb_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus_4;
  logic        o_valid;

  fetch_unit #(.RESET_ADDR(RESET_ADDR)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (i_stall),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_valid       (o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  // stimulus knobs
  logic        rst, rdy, stl, rdr;
  logic [31:0] rpc;
  int          lat;

  // memory model and expectation state
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  logic        held;
  logic [31:0] exp_pc;
  int          n_val;
  int          n_cons;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return a | 32'h0000_0100;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later, then
  // advance through the rising edge and update the expectation state.
  task automatic tick();
    logic        rv, ev, er, acc;
    logic [31:0] acc_pc;
    rv            = mem_pend && (mem_wait == 0);
    i_rst         = rst;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mem_data(mem_addr) : 32'hBAD0_BAD0;
    i_imem_ready  = rdy;
    i_stall       = stl;
    i_redirect    = rdr;
    i_redirect_pc = rpc;
    #1;
    if (o_valid) n_val++;
    ev = 1'b0;
    if (rst) begin
      check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
      check_eq("rst_instr", o_instruction, NOP);
    end else begin
      ev = !rdr && ((rv && sb_q.size() != 0) || held);
      er = !rdr && !mem_pend && !held;
      check_eq("valid", {31'd0, o_valid}, {31'd0, ev});
      check_eq("pc", o_pc, exp_pc);
      check_eq("pc_plus_4", o_pc_plus_4, exp_pc + 32'd4);
      check_eq("req", {31'd0, o_imem_req}, {31'd0, er});
      if (er) check_eq("req_addr", o_imem_addr, exp_pc);
      if (ev && sb_q.size() != 0) begin
        check_eq("sb_instr", o_instruction, sb_q[0].instr);
        check_eq("sb_pc", o_pc, sb_q[0].pc);
      end else if (!ev) begin
        check_eq("nop", o_instruction, NOP);
      end
    end
    acc    = !rst && o_imem_req && rdy && !mem_pend;
    acc_pc = o_imem_addr;
    @(posedge i_clk);
    if (rst) begin
      sb_q.delete();
      mem_pend = 1'b0;
      held     = 1'b0;
      exp_pc   = RESET_ADDR;
    end else begin
      if (rdr) begin
        sb_q.delete();
        held   = 1'b0;
        exp_pc = {rpc[31:2], 2'b00};
      end else if (ev && !stl) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        held   = 1'b0;
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end else if (ev) begin
        held = 1'b1;
      end
      if (rv)            mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (acc) begin
        mem_pend = 1'b1;
        mem_addr = acc_pc;
        mem_wait = lat - 1;
        sb_q.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
      end
    end
    @(negedge i_clk);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stl = 1'b0; rdr = 1'b0; rpc = '0; lat = 1;
    mem_pend = 1'b0; mem_addr = '0; mem_wait = 0; held = 1'b0;
    exp_pc = RESET_ADDR; n_val = 0; n_cons = 0;
    i_rst = 1'b1; i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_stall = 1'b0;
    @(negedge i_clk);
    tick(); tick();
    rst = 1'b0;

    // memory not ready: request held at the reset address
    rdy = 1'b0;
    n_val = 0;
    repeat (3) tick();
    check_eq("notready_valid_cnt", n_val, 0);

    // zero-wait streaming: one instruction every two cycles
    rdy = 1'b1;
    n_cons = 0;
    repeat (8) tick();
    check_eq("stream_consumed", n_cons, 4);

    // stall held four cycles as 0xDEADBEEF returns for pc 0x10
    tick();
    stl = 1'b1;
    n_val = 0;
    repeat (4) tick();
    stl = 1'b0;
    tick();
    check_eq("stall_valid_cycles", n_val, 5);
    #1;
    check_eq("after_stall_addr", o_imem_addr, 32'h0000_0014);

    // redirect while waiting; stale response arrives two cycles later
    lat = 3;
    tick();
    rdr = 1'b1; rpc = 32'h0000_0200;
    tick();
    rdr = 1'b0;
    n_val = 0;
    tick(); tick();
    check_eq("drop_valid_cnt", n_val, 0);
    lat = 1;
    n_cons = 0;
    tick(); tick();
    check_eq("redirect_target_consumed", n_cons, 1);

    // redirect to an unaligned target in the same cycle as rvalid
    tick();
    rdr = 1'b1; rpc = 32'h0000_0403;
    tick();
    rdr = 1'b0;
    #1;
    check_eq("redir_rvalid_addr", o_imem_addr, 32'h0000_0400);
    tick(); tick();

    // pc wrap at the top of the address space
    rdr = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    rdr = 1'b0;
    tick();
    #1;
    check_eq("wrap_pc_plus_4", o_pc_plus_4, 32'h0000_0000);
    tick();
    #1;
    check_eq("wrap_next_addr", o_imem_addr, 32'h0000_0000);
    tick(); tick();

    // reset while holding a stalled instruction at pc 4
    tick();
    stl = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stl = 1'b0;
    #1;
    check_eq("post_rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("post_rst_instr", o_instruction, NOP);
    check_eq("post_rst_pc", o_pc, RESET_ADDR);
    n_cons = 0;
    repeat (4) tick();
    check_eq("post_rst_consumed", n_cons, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
